mux: RTL and testbench

- 4:1 data multiplexer with active-high enable and a registered output stage.
- Selects one of four data inputs D0..D3 using two select bits (S2 = MSB, S1 = LSB) and drives the result onto Y.
- Used as a generic leaf selector in datapaths. The output register isolates downstream timing.
- Optional combinational bypass is available via a parameter.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/mux_sel_decode.sv | 26 ++
 rtl/mux.sv | 71 +++++++
 tb/tb_mux.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select constants, types and one-hot helper for mux
package mux_pkg;

   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_D0 = 2'd0;
   localparam sel_t SEL_D1 = 2'd1;
   localparam sel_t SEL_D2 = 2'd2;
   localparam sel_t SEL_D3 = 2'd3;

   // One-hot of a select index: bit n set when s == n
   function automatic logic [NUM_IN-1:0] sel_to_onehot(input sel_t s);
      logic [NUM_IN-1:0] v;
      v = {{(NUM_IN-1){1'b0}}, 1'b1};
      return v << s;
   endfunction

endpackage

// File: rtl/mux_sel_decode.sv
// rtl/mux_sel_decode.sv - select bit packing and enable-gated one-hot decode
module mux_sel_decode
   import mux_pkg::*;
(
   input  logic              i_s1,
   input  logic              i_s2,
   input  logic              i_en,
   output sel_t              o_idx,
   output logic [NUM_IN-1:0] o_onehot
);

   sel_t w_idx;

   // S2 is the MSB even though S1 comes first on the ports
   assign w_idx = {i_s2, i_s1};
   assign o_idx = w_idx;

   // One-hot is forced to zero whenever the mux is disabled
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot = sel_to_onehot(w_idx);
      end
   end

endmodule

// File: rtl/mux.sv
// rtl/mux.sv - 4:1 enable-gated data mux with optional registered output
module mux
   import mux_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             S1,
   input  logic             S2,
   input  logic             E,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   output logic [WIDTH-1:0] Y,
   output logic [3:0]       sel_onehot
);

   sel_t              w_sel;
   logic [NUM_IN-1:0] w_onehot;
   logic [WIDTH-1:0]  w_nxt;
   logic [WIDTH-1:0]  r_y;
   logic [NUM_IN-1:0] r_onehot;

   mux_sel_decode u_decode (
      .i_s1     (S1),
      .i_s2     (S2),
      .i_en     (E),
      .o_idx    (w_sel),
      .o_onehot (w_onehot)
   );

   // Next output value: selected input when enabled, otherwise all zeros
   always_comb begin
      w_nxt = '0;
      if (E) begin
         case (w_sel)
            SEL_D0:  w_nxt = D0;
            SEL_D1:  w_nxt = D1;
            SEL_D2:  w_nxt = D2;
            SEL_D3:  w_nxt = D3;
            default: w_nxt = '0;
         endcase
      end
   end

   // Output register; kept in bypass mode too so reset behaviour is uniform
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y      <= '0;
         r_onehot <= '0;
      end else begin
         r_y      <= w_nxt;
         r_onehot <= w_onehot;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         assign Y          = r_y;
         assign sel_onehot = r_onehot;
      end else begin : g_comb_out
         // Bypass still honours reset so Y is zero while rst_n is low
         assign Y          = rst_n ? w_nxt    : '0;
         assign sel_onehot = rst_n ? w_onehot : 4'b0000;
      end
   endgenerate

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - directed self-checking bench for mux (registered, 8-bit and bypass builds)
`timescale 1ns/1ps
module tb_mux;

   logic       clk;
   logic       rst_n;
   logic       S1, S2, E;
   logic       D0, D1, D2, D3;
   logic [7:0] B0, B1, B2, B3;
   logic       Y_r, Y_c;
   logic [7:0] Y_w;
   logic [3:0] oh_r, oh_c, oh_w;

   int n_pass;
   int n_total;

   mux #(.WIDTH(1), .REG_OUT(1'b1)) u_reg (
      .clk(clk), .rst_n(rst_n), .S1(S1), .S2(S2), .E(E),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3), .Y(Y_r), .sel_onehot(oh_r)
   );

   mux #(.WIDTH(8), .REG_OUT(1'b1)) u_wide (
      .clk(clk), .rst_n(rst_n), .S1(S1), .S2(S2), .E(E),
      .D0(B0), .D1(B1), .D2(B2), .D3(B3), .Y(Y_w), .sel_onehot(oh_w)
   );

   mux #(.WIDTH(1), .REG_OUT(1'b0)) u_byp (
      .clk(clk), .rst_n(rst_n), .S1(S1), .S2(S2), .E(E),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3), .Y(Y_c), .sel_onehot(oh_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; E = 1'b1; S2 = 1'b1; S1 = 1'b1; D3 = 1'b1;
      #1;
      n_total++; if (Y_r !== 1'b0) $display("FAIL reset_y got=%b exp=0", Y_r); else n_pass++;
      n_total++; if (oh_r !== 4'b0000) $display("FAIL reset_onehot got=%b exp=0000", oh_r); else n_pass++;
      n_total++; if (Y_c !== 1'b0) $display("FAIL reset_byp_y got=%b exp=0", Y_c); else n_pass++;
      n_total++; if (oh_c !== 4'b0000) $display("FAIL reset_byp_onehot got=%b exp=0000", oh_c); else n_pass++;
      #1 rst_n = 1'b1;
      #1;
      n_total++; if (Y_r !== 1'b0) $display("FAIL reset_hold_before_edge got=%b exp=0", Y_r); else n_pass++;
      n_total++; if (Y_c !== 1'b1) $display("FAIL reset_byp_release got=%b exp=1", Y_c); else n_pass++;
      step();
      n_total++; if (Y_r !== 1'b1) $display("FAIL reset_first_edge_y got=%b exp=1", Y_r); else n_pass++;
      n_total++; if (oh_r !== 4'b1000) $display("FAIL reset_first_edge_onehot got=%b exp=1000", oh_r); else n_pass++;
   endtask

   task automatic test_select_sweep();
      logic [1:0] order [4];
      logic [3:0] oh_exp [4];
      logic       exp_y;
      order[0] = 2'b00; oh_exp[0] = 4'b0001;
      order[1] = 2'b11; oh_exp[1] = 4'b1000;
      order[2] = 2'b01; oh_exp[2] = 4'b0010;
      order[3] = 2'b10; oh_exp[3] = 4'b0100;
      E = 1'b1;
      for (int k = 0; k < 4; k++) begin
         {S2, S1} = order[k];
         for (int i = 0; i < 4; i++) begin
            D0 = i[0]; D1 = ~i[0]; D2 = i[1]; D3 = ~i[1];
            case (order[k])
               2'b00:   exp_y = i[0];
               2'b01:   exp_y = ~i[0];
               2'b10:   exp_y = i[1];
               default: exp_y = ~i[1];
            endcase
            step();
            n_total++;
            if (Y_r !== exp_y)
               $display("FAIL sweep_y sel=%b step=%0d got=%b exp=%b", order[k], i, Y_r, exp_y);
            else n_pass++;
         end
         n_total++;
         if (oh_r !== oh_exp[k])
            $display("FAIL sweep_onehot sel=%b got=%b exp=%b", order[k], oh_r, oh_exp[k]);
         else n_pass++;
      end
   endtask

   task automatic test_enable();
      E = 1'b0; S2 = 1'b1; S1 = 1'b0; D2 = 1'b1;
      step();
      n_total++; if (Y_r !== 1'b0) $display("FAIL enable_off_y got=%b exp=0", Y_r); else n_pass++;
      n_total++; if (oh_r !== 4'b0000) $display("FAIL enable_off_onehot got=%b exp=0000", oh_r); else n_pass++;
      n_total++; if (oh_c !== 4'b0000) $display("FAIL enable_off_byp_onehot got=%b exp=0000", oh_c); else n_pass++;
      E = 1'b1;
      #1;
      n_total++; if (Y_r !== 1'b0) $display("FAIL enable_latency got=%b exp=0", Y_r); else n_pass++;
      step();
      n_total++; if (Y_r !== 1'b1) $display("FAIL enable_on_y got=%b exp=1", Y_r); else n_pass++;
      n_total++; if (oh_r !== 4'b0100) $display("FAIL enable_on_onehot got=%b exp=0100", oh_r); else n_pass++;
   endtask

   task automatic test_width();
      logic [7:0] exp_w [4];
      exp_w[0] = 8'hA5; exp_w[1] = 8'h3C; exp_w[2] = 8'hFF; exp_w[3] = 8'h00;
      B0 = 8'hA5; B1 = 8'h3C; B2 = 8'hFF; B3 = 8'h00; E = 1'b1;
      // park on D2 so every later select change is visible on Y
      {S2, S1} = 2'b10;
      step();
      for (int k = 0; k < 4; k++) begin
         logic [7:0] prev;
         prev = Y_w;
         {S2, S1} = k[1:0];
         #1;
         n_total++;
         if (Y_w !== prev) $display("FAIL width_hold sel=%0d got=%h exp=%h", k, Y_w, prev); else n_pass++;
         step();
         n_total++;
         if (Y_w !== exp_w[k]) $display("FAIL width_y sel=%0d got=%h exp=%h", k, Y_w, exp_w[k]); else n_pass++;
      end
   endtask

   task automatic test_bypass();
      E = 1'b1; S2 = 1'b0; S1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         D1 = i[0];
         #1;
         n_total++;
         if (Y_c !== i[0]) $display("FAIL bypass_follow step=%0d got=%b exp=%b", i, Y_c, i[0]); else n_pass++;
      end
      D1 = 1'b1;
      #1;
      n_total++; if (oh_c !== 4'b0010) $display("FAIL bypass_onehot got=%b exp=0010", oh_c); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (Y_c !== 1'b0) $display("FAIL bypass_reset got=%b exp=0", Y_c); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++; if (Y_c !== 1'b1) $display("FAIL bypass_after_reset got=%b exp=1", Y_c); else n_pass++;
   endtask

   task automatic test_async_reset();
      E = 1'b1; S2 = 1'b0; S1 = 1'b0; D0 = 1'b1;
      step();
      n_total++; if (Y_r !== 1'b1) $display("FAIL async_pre got=%b exp=1", Y_r); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (Y_r !== 1'b0) $display("FAIL async_drop got=%b exp=0", Y_r); else n_pass++;
      step();
      n_total++; if (Y_r !== 1'b0) $display("FAIL async_held_edge got=%b exp=0", Y_r); else n_pass++;
      #2 rst_n = 1'b1;
      #1;
      n_total++; if (Y_r !== 1'b0) $display("FAIL async_release_wait got=%b exp=0", Y_r); else n_pass++;
      step();
      n_total++; if (Y_r !== 1'b1) $display("FAIL async_resume got=%b exp=1", Y_r); else n_pass++;
      n_total++; if (oh_r !== 4'b0001) $display("FAIL async_resume_onehot got=%b exp=0001", oh_r); else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b0; S1 = 1'b0; S2 = 1'b0; E = 1'b0;
      D0 = 1'b0; D1 = 1'b0; D2 = 1'b0; D3 = 1'b0;
      B0 = '0; B1 = '0; B2 = '0; B3 = '0;
      test_reset();
      test_select_sweep();
      test_enable();
      test_width();
      test_bypass();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
